// File: rtl/video_pkg.sv
// Shared video constants and types for the frame-buffer display path.
// Contents:
//   H_RES, V_RES       visible raster size
//   FB_W, FB_H         frame-buffer size (screen is 2x scaled in both axes)
//   IDX_W, RD_LAT      palette index width, frame-buffer RAM read latency
//   FRAME1_BASE        word address of frame 1 (frame 0 starts at 0)
//   rgb_t, pal_idx_t, fb_addr_t
//   fb_offset()        frame-relative word offset of a scaled coordinate
package video_pkg;

   localparam int H_RES       = 640;
   localparam int V_RES       = 480;
   localparam int FB_W        = 320;
   localparam int FB_H        = 240;
   localparam int IDX_W       = 4;
   localparam int RD_LAT      = 2;
   localparam int FRAME1_BASE = 76800;

   typedef logic [23:0]      rgb_t;
   typedef logic [IDX_W-1:0] pal_idx_t;
   typedef logic [17:0]      fb_addr_t;

   // ys*320 + xs built from shifts and adds: ys*320 = (ys<<8) + (ys<<6).
   // Largest result is 239*320 + 319 = 76799, well inside 18 bits.
   function automatic fb_addr_t fb_offset(input logic [8:0] xs, input logic [8:0] ys);
      fb_addr_t y_ext;
      fb_addr_t x_ext;
      y_ext = {9'd0, ys};
      x_ext = {9'd0, xs};
      return (y_ext << 8) + (y_ext << 6) + x_ext;
   endfunction

endpackage

// File: rtl/palette_rf.sv
// 16 x 24-bit palette register file.
// Ports:
//   clk, rst          clock, asynchronous active-high reset (clears all entries)
//   we, waddr, wdata  write port, applied at the clock edge
//   re, raddr         read request; the read is sampled at the clock edge
//   rdata             registered read data; 0 after a cycle without re
// A read and a write of the same entry at one edge return the old entry,
// since the read samples the array before the write lands.
module palette_rf
   import video_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  logic     we,
   input  pal_idx_t waddr,
   input  rgb_t     wdata,
   input  logic     re,
   input  pal_idx_t raddr,
   output rgb_t     rdata
);

   localparam int N_ENTRIES = 2 ** IDX_W;

   rgb_t mem [N_ENTRIES];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_ENTRIES; i++) begin
            mem[i] <= '0;
         end
         rdata <= '0;
      end else begin
         if (we) begin
            mem[waddr] <= wdata;
         end
         rdata <= re ? mem[raddr] : '0;
      end
   end

endmodule

// File: rtl/frame_reader.sv
// Turns VGA coordinates into frame-buffer reads and palette-mapped RGB.
// Ports:
//   Clk, Reset            pixel clock, asynchronous active-high reset
//   DrawX, DrawY          current raster coordinate
//   swap_req              pulse: swap displayed frame at next vertical blank
//   pal_we/waddr/wdata    palette write port
//   fb_rd, fb_addr        frame-buffer read request (one cycle after sampling)
//   fb_rdata              palette index, valid RD_LAT cycles after fb_rd
//   color_data/valid      RGB out, RD_LAT+2 cycles after the coordinate
//   frame_sel             frame being displayed
//   swap_done             pulse when a swap takes effect
// Pipeline: A (address) -> B1..B(RD_LAT) (RAM latency) -> C (palette read).
module frame_reader
   import video_pkg::*;
(
   input  logic       Clk,
   input  logic       Reset,
   input  logic [9:0] DrawX,
   input  logic [9:0] DrawY,
   input  logic       swap_req,
   input  logic       pal_we,
   input  pal_idx_t   pal_waddr,
   input  rgb_t       pal_wdata,
   output logic       fb_rd,
   output fb_addr_t   fb_addr,
   input  pal_idx_t   fb_rdata,
   output rgb_t       color_data,
   output logic       color_valid,
   output logic       frame_sel,
   output logic       swap_done
);

   localparam logic [9:0] H_LIM = 10'(H_RES);
   localparam logic [9:0] V_LIM = 10'(V_RES);

   logic              visible;
   logic              boundary;
   logic              swap_now;
   logic              pending;
   fb_addr_t          base;
   logic [RD_LAT-1:0] rd_pipe;
   logic              lookup_vld;

   assign visible  = (DrawX < H_LIM) && (DrawY < V_LIM);
   // First cycle of vertical blank: the only point where the frame may flip.
   assign boundary = (DrawY == V_LIM) && (DrawX == 10'd0);
   assign swap_now = boundary && (pending || swap_req);
   assign base     = frame_sel ? fb_addr_t'(FRAME1_BASE) : fb_addr_t'(0);

   // Stage A: address generation; fb_addr holds across blanking.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         fb_rd   <= 1'b0;
         fb_addr <= '0;
      end else begin
         fb_rd <= visible;
         if (visible) begin
            fb_addr <= base + fb_offset(DrawX[9:1], DrawY[9:1]);
         end
      end
   end

   // Stages B: valid bit travels alongside the RAM read so that its last
   // tap is high exactly in the cycle fb_rdata carries the index.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         rd_pipe <= '0;
      end else begin
         rd_pipe[0] <= fb_rd;
         for (int i = 1; i < RD_LAT; i++) begin
            rd_pipe[i] <= rd_pipe[i-1];
         end
      end
   end

   assign lookup_vld = rd_pipe[RD_LAT-1];

   // Stage C: registered palette read; returns 0 for non-visible slots.
   palette_rf u_palette (
      .clk   (Clk),
      .rst   (Reset),
      .we    (pal_we),
      .waddr (pal_waddr),
      .wdata (pal_wdata),
      .re    (lookup_vld),
      .raddr (fb_rdata),
      .rdata (color_data)
   );

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         color_valid <= 1'b0;
      end else begin
         color_valid <= lookup_vld;
      end
   end

   // Frame swap: requests collapse into one pending bit, consumed only at
   // the boundary, so frame_sel never moves during visible lines.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         pending   <= 1'b0;
         frame_sel <= 1'b0;
         swap_done <= 1'b0;
      end else begin
         swap_done <= swap_now;
         if (swap_now) begin
            frame_sel <= ~frame_sel;
         end
         if (boundary) begin
            pending <= 1'b0;
         end else if (swap_req) begin
            pending <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_frame_reader.sv
// Self-checking bench for frame_reader: directed coordinates, a RAM model
// answering reads after RD_LAT cycles, and a transaction-level model of the
// expected outputs compared every cycle.
module tb_frame_reader;
   import video_pkg::*;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic [9:0] DrawX = '0;
   logic [9:0] DrawY = '0;
   logic       swap_req = 1'b0;
   logic       pal_we = 1'b0;
   pal_idx_t   pal_waddr = '0;
   rgb_t       pal_wdata = '0;
   logic       fb_rd;
   fb_addr_t   fb_addr;
   pal_idx_t   fb_rdata = '0;
   rgb_t       color_data;
   logic       color_valid;
   logic       frame_sel;
   logic       swap_done;

   int errors = 0;
   int checks = 0;
   bit started = 1'b0;

   frame_reader dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .DrawX       (DrawX),
      .DrawY       (DrawY),
      .swap_req    (swap_req),
      .pal_we      (pal_we),
      .pal_waddr   (pal_waddr),
      .pal_wdata   (pal_wdata),
      .fb_rd       (fb_rd),
      .fb_addr     (fb_addr),
      .fb_rdata    (fb_rdata),
      .color_data  (color_data),
      .color_valid (color_valid),
      .frame_sel   (frame_sel),
      .swap_done   (swap_done)
   );

   // ---------------- clock ----------------
   always #5 Clk = ~Clk;

   // Frame-buffer contents: index derived from the word address.
   function automatic pal_idx_t ram_idx(input int a);
      logic [17:0] w;
      w = a[17:0];
      return w[3:0] + w[7:4] + 4'd3;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- RAM model ----------------
   // Answers the read issued RD_LAT cycles earlier; junk otherwise.
   bit r_v [RD_LAT+1];
   int r_a [RD_LAT+1];
   initial begin
      for (int i = 0; i <= RD_LAT; i++) begin
         r_v[i] = 1'b0;
         r_a[i] = 0;
      end
   end
   always @(negedge Clk) begin
      for (int i = RD_LAT; i > 0; i--) begin
         r_v[i] = r_v[i-1];
         r_a[i] = r_a[i-1];
      end
      r_v[0] = fb_rd;
      r_a[0] = int'(fb_addr);
      fb_rdata = r_v[RD_LAT] ? ram_idx(r_a[RD_LAT]) : pal_idx_t'($urandom_range(15, 0));
   end

   // ---------------- reference model ----------------
   typedef struct {
      bit v;
      int a;
   } samp_t;

   samp_t hist [$];
   rgb_t  pal_m [16];
   bit    exp_fb_rd = 0;
   int    exp_fb_addr = 0;
   bit    exp_valid = 0;
   rgb_t  exp_color = '0;
   bit    exp_frame = 0;
   bit    exp_done = 0;
   bit    pend = 0;

   initial begin
      for (int i = 0; i < 16; i++) pal_m[i] = '0;
   end

   always @(posedge Clk or posedge Reset) begin
      samp_t s;
      bit    vis;
      bit    bnd;
      if (Reset) begin
         hist.delete();
         for (int i = 0; i < 16; i++) pal_m[i] = '0;
         exp_fb_rd = 0; exp_fb_addr = 0; exp_valid = 0; exp_color = '0;
         exp_frame = 0; exp_done = 0; pend = 0;
      end else begin
         // Output for the coordinate sampled three edges ago, palette as it
         // stood before any write at this edge.
         if (hist.size() == 3) begin
            s = hist.pop_front();
            exp_valid = s.v;
            exp_color = s.v ? pal_m[ram_idx(s.a)] : 24'h0;
         end else begin
            exp_valid = 0;
            exp_color = '0;
         end
         vis = (int'(DrawX) < 640) && (int'(DrawY) < 480);
         exp_fb_rd = vis;
         if (vis) exp_fb_addr = (exp_frame ? 76800 : 0) + (int'(DrawY) / 2) * 320 + int'(DrawX) / 2;
         s.v = vis;
         s.a = exp_fb_addr;
         hist.push_back(s);
         bnd = (int'(DrawY) == 480) && (int'(DrawX) == 0);
         exp_done = bnd && (pend || swap_req);
         if (exp_done) exp_frame = !exp_frame;
         pend = bnd ? 1'b0 : (pend || swap_req);
         if (pal_we) pal_m[pal_waddr] = pal_wdata;
      end
   end

   // ---------------- scoreboard compare ----------------
   always @(negedge Clk) begin
      if (started && !Reset) begin
         check("fb_rd", 32'(fb_rd), 32'(exp_fb_rd));
         check("fb_addr", 32'(fb_addr), 32'(exp_fb_addr));
         check("color_valid", 32'(color_valid), 32'(exp_valid));
         check("color_data", 32'(color_data), 32'(exp_color));
         check("frame_sel", 32'(frame_sel), 32'(exp_frame));
         check("swap_done", 32'(swap_done), 32'(exp_done));
      end
   end

   // ---------------- driver ----------------
   task automatic step(input int x, input int y, input bit sw = 0, input bit we = 0,
                       input int wa = 0, input logic [23:0] wd = 24'h0);
      DrawX     = x[9:0];
      DrawY     = y[9:0];
      swap_req  = sw;
      pal_we    = we;
      pal_waddr = wa[3:0];
      pal_wdata = wd;
      @(negedge Clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(700, 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      repeat (3) @(negedge Clk);
      check("reset_fb_rd", 32'(fb_rd), 32'h0);
      check("reset_color_valid", 32'(color_valid), 32'h0);
      check("reset_frame_sel", 32'(frame_sel), 32'h0);
      started = 1'b1;
      Reset = 1'b0;

      // palette load
      for (int i = 0; i < 16; i++) begin
         logic [23:0] v;
         v = (i == 3) ? 24'hFF8000 : (i == 5) ? 24'h123456 : 24'($urandom_range(24'hFFFFFF, 0));
         step(700, 0, 0, 1, i, v);
      end

      // first pixel: address after one cycle, colour after four
      step(0, 0);
      check("first_fb_rd", 32'(fb_rd), 32'h1);
      check("first_fb_addr", 32'(fb_addr), 32'h0);
      idle(3);
      check("first_valid", 32'(color_valid), 32'h1);
      check("first_color", 32'(color_data), 32'hFF8000);

      // write to entry 5 in the same cycle as its lookup
      step(4, 0);
      idle(2);
      step(700, 0, 0, 1, 5, 24'h00FF00);
      check("wr_same_cycle_old", 32'(color_data), 32'h123456);
      step(4, 0);
      idle(3);
      check("wr_next_new", 32'(color_data), 32'h00FF00);

      // swap requested mid-frame waits for vertical blank
      step(0, 100, 1);
      step(0, 200);
      check("swap_wait_frame", 32'(frame_sel), 32'h0);
      step(0, 480);
      check("swap_frame", 32'(frame_sel), 32'h1);
      check("swap_done_pulse", 32'(swap_done), 32'h1);
      step(1, 480);
      check("swap_done_clear", 32'(swap_done), 32'h0);

      // last pixel of frame 1
      step(639, 479);
      check("last_fb_rd", 32'(fb_rd), 32'h1);
      check("last_fb_addr", 32'(fb_addr), 32'd153599);

      // two requests collapse into one toggle
      step(5, 100, 1);
      step(6, 200, 1);
      step(0, 480);
      check("double_req_frame", 32'(frame_sel), 32'h0);
      step(2, 480);
      check("double_req_once", 32'(frame_sel), 32'h0);

      // request exactly at the boundary
      step(0, 480, 1);
      check("bnd_req_frame", 32'(frame_sel), 32'h1);
      // request just after the boundary waits a frame
      step(1, 480, 1);
      check("post_bnd_hold", 32'(frame_sel), 32'h1);
      step(10, 10);
      step(0, 480);
      check("post_bnd_next", 32'(frame_sel), 32'h0);
      step(0, 100, 1);
      step(0, 480);

      // blanking: no read, address held
      step(20, 10);
      step(700, 10);
      check("hblank_fb_rd", 32'(fb_rd), 32'h0);
      check("hblank_addr_hold", 32'(fb_addr), 32'd78410);
      step(30, 490);
      check("vblank_fb_rd", 32'(fb_rd), 32'h0);
      idle(2);
      check("hblank_valid", 32'(color_valid), 32'h0);
      check("hblank_color", 32'(color_data), 32'h0);

      // mixed coordinates through the pipeline
      for (int i = 0; i < 48; i++) begin
         step((i * 37 + 3) % 800, (i * 53) % 525, (i % 11) == 0, (i % 7) == 0,
              i % 16, 24'($urandom_range(24'hFFFFFF, 0)));
      end

      // reset with visible pixels in flight
      step(10, 10); step(12, 20); step(14, 30); step(16, 40); step(18, 50);
      check("inflight_valid", 32'(color_valid), 32'h1);
      #2 Reset = 1'b1;
      #1;
      check("async_valid", 32'(color_valid), 32'h0);
      check("async_color", 32'(color_data), 32'h0);
      check("async_frame", 32'(frame_sel), 32'h0);
      @(negedge Clk);
      @(negedge Clk);
      Reset = 1'b0;
      step(0, 0);
      idle(3);
      check("post_reset_valid", 32'(color_valid), 32'h1);
      check("post_reset_pal", 32'(color_data), 32'h0);
      idle(4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/frame_reader.md
Name: frame_reader

Overview:
- Producer of the 24-bit `color_data` word that the colour mapper splits into VGA_R/G/B.
- Sits between the VGA timing generator (DrawX/DrawY) and the on-chip frame buffer RAM.
- Converts each screen coordinate into a frame-buffer read, fetches a palette index, and maps it through a CPU-writable 16-entry RGB palette.
- Supports double-buffered frames, swapped only at the start of vertical blank.

Parameters:
- H_RES, 640, visible pixels per line.
- V_RES, 480, visible lines.
- FB_W, 320, frame-buffer width in pixels; the screen is FB 2x-scaled in both axes.
- FB_H, 240, frame-buffer height in lines.
- IDX_W, 4, palette index width (2**IDX_W palette entries).
- RD_LAT, 2, frame-buffer RAM read latency in Clk cycles (>=1).
- FRAME1_BASE, 76800, word address of frame 1; frame 0 base is 0.

Ports:
- Clk  in  1  pixel clock; all logic is in this single domain.
- Reset  in  1  asynchronous, active-high reset.
- DrawX  in  10  current pixel column from the VGA controller.
- DrawY  in  10  current pixel row from the VGA controller.
- swap_req  in  1  one-cycle pulse requesting a frame-buffer swap.
- pal_we  in  1  palette write strobe.
- pal_waddr  in  IDX_W  palette entry to write.
- pal_wdata  in  24  RGB 8:8:8 value to write.
- fb_rd  out  1  frame-buffer read strobe.
- fb_addr  out  18  frame-buffer word address.
- fb_rdata  in  IDX_W  palette index, valid exactly RD_LAT cycles after fb_rd.
- color_data  out  24  RGB to the colour mapper; 0 when not visible.
- color_valid  out  1  high when color_data corresponds to a visible pixel.
- frame_sel  out  1  frame currently being displayed.
- swap_done  out  1  one-cycle pulse when a swap takes effect.

Behaviour:
- Reset (async, high): clear fb_rd, fb_addr, color_data, color_valid, frame_sel, swap_done, the swap-pending bit, all pipeline valid bits, and all 16 palette entries. Releasing reset mid-frame starts cleanly from the next sampled coordinate.
- Visible pixel: DrawX < H_RES and DrawY < V_RES.
- Stage A, sampled every Clk:
  - If visible: fb_rd=1 and fb_addr = base + (DrawY>>1)*FB_W + (DrawX>>1), where base is 0 or FRAME1_BASE according to frame_sel.
  - Compute with shifts/adds: y*320 = (y<<8)+(y<<6).
  - Width: the 18-bit result never exceeds 153599.
  - If not visible: fb_rd=0; fb_addr holds its previous value.
- Stages B1..B(RD_LAT): a valid bit delay line aligned with RAM latency; fb_rdata is captured when the delay line output is valid.
- Stage C, palette lookup (registered):
  - color_data = palette[idx] and color_valid=1 when valid.
  - Otherwise color_data = 24'h000000 and color_valid=0.
- Total latency: coordinate sample to color_data is RD_LAT+2 cycles (4 by default). The VGA controller delays sync by the same amount.
- Palette:
  - Register file written on pal_we at Clk edge.
  - A lookup of the same index in the same cycle as a write returns the old value; the new value is visible from the next cycle.
  - Writes are accepted at any time, including during active video.
- Frame swap:
  - A swap_req pulse sets pending.
  - Boundary: the cycle with DrawY==V_RES and DrawX==0. At the boundary, if pending (or swap_req in that same cycle), toggle frame_sel, clear pending, and pulse swap_done for one cycle.
  - Multiple requests before a boundary collapse into one swap.
  - swap_req in the cycle after the boundary waits for the next frame.
- frame_sel never changes during visible lines, so no mid-frame tearing.

Decomposition:
- Shared package `video_pkg`:
  - constants H_RES, V_RES, FB_W, FB_H, FRAME1_BASE;
  - typedef rgb_t (logic [23:0]);
  - typedef pal_idx_t (logic [IDX_W-1:0]);
  - typedef fb_addr_t (logic [17:0]).
- One sub-module `palette_rf`: 16x24 register file with async reset, one write port, and one registered read port.

Test Plan:
- Reset then DrawX=0, DrawY=0, RAM model returns idx 3 with palette[3]=24'hFF8000 → fb_rd=1 and fb_addr=0 one cycle after sampling; color_data=FF8000 and color_valid=1 exactly 4 cycles after sampling.
- DrawX=639, DrawY=479, frame_sel=1 → fb_addr = 76800 + 239*320 + 319 = 153599.
- DrawX=640..799 (hblank) or DrawY>=480 → fb_rd=0; 4 cycles later color_valid=0 and color_data=0.
- Write palette[5]=24'h00FF00 in the same cycle the lookup of idx 5 happens (old 24'h123456) → output 123456 that pixel, 00FF00 on the next idx-5 pixel.
- Swap:
  - swap_req at DrawY=100 → frame_sel stays 0 until DrawY=480/DrawX=0, then becomes 1 with a one-cycle swap_done.
  - Two requests in one frame → a single toggle.
  - swap_req exactly at the boundary → toggle in that cycle.
- Assert Reset while visible pixels are in flight → color_valid and color_data drop to 0 immediately (async), palette reads 0, frame_sel=0.
